// File: rtl/uart_imem_loader.sv
// uart_imem_loader
// Serial program loader: receives 8N1 UART bytes, assembles little-endian
// 32-bit words and writes them to instruction memory at consecutive word
// addresses, holding the core in reset while a load is in progress.
// Stream format: count byte N (0 means 256), then 4*N payload bytes.
// Optional feature macro: LOADER_CHECKSUM_EN -- when defined, one trailing
// byte equal to the XOR of all payload bytes is expected and verified.
`timescale 1ns/1ps
module uart_imem_loader #(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned BAUD           = 115200,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        load_en,
    output logic        core_hold,
    output logic        imem_we,
    output logic [7:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        load_done,
    output logic        load_err
);

    // Clocks per UART bit, rounded to nearest.
    localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_BITS  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        L_IDLE   = 2'd0,
        L_WORDS  = 2'd1,
`ifdef LOADER_CHECKSUM_EN
        L_CHECK  = 2'd2,
`endif
        L_FINISH = 2'd3
    } ld_state_t;

`ifdef LOADER_CHECKSUM_EN
    // Running XOR checksum over payload bytes.
    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] data);
        csum_next = acc ^ data;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Input synchronizer and edge history
    // ------------------------------------------------------------------
    logic rx_meta_r;
    logic rxs_r;
    logic rxs_prev_r;

    // Two-flop synchronizer for the asynchronous rx line, plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r  <= 1'b1;
            rxs_r      <= 1'b1;
            rxs_prev_r <= 1'b1;
        end else begin
            rx_meta_r  <= rx;
            rxs_r      <= rx_meta_r;
            rxs_prev_r <= rxs_r;
        end
    end

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    rx_state_t     rx_state_r;
    logic [CW-1:0] bit_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic [7:0]    byte_r;
    logic          byte_vld_r;
    logic          frame_err_r;

    // 8N1 receiver: start-bit validation at half a bit, then one sample per bit time.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_r  <= RX_IDLE;
            bit_cnt_r   <= {CW{1'b0}};
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'd0;
            byte_r      <= 8'd0;
            byte_vld_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            byte_vld_r  <= 1'b0;
            frame_err_r <= 1'b0;
            if (!load_en) begin
                // Disarmed loader ignores the line entirely.
                rx_state_r <= RX_IDLE;
                bit_cnt_r  <= {CW{1'b0}};
                bit_idx_r  <= 3'd0;
            end else begin
                case (rx_state_r)
                    RX_IDLE: begin
                        if (rxs_prev_r && !rxs_r) begin
                            rx_state_r <= RX_START;
                            bit_cnt_r  <= {CW{1'b0}};
                        end
                    end
                    RX_START: begin
                        if (bit_cnt_r == HALF_LAST) begin
                            bit_cnt_r <= {CW{1'b0}};
                            if (!rxs_r) begin
                                rx_state_r <= RX_BITS;
                                bit_idx_r  <= 3'd0;
                            end else begin
                                // Line went back high: glitch, not a start bit.
                                rx_state_r <= RX_IDLE;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CW'(1);
                        end
                    end
                    RX_BITS: begin
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_r <= {CW{1'b0}};
                            shift_r   <= {rxs_r, shift_r[7:1]};
                            if (bit_idx_r == 3'd7) begin
                                rx_state_r <= RX_STOP;
                            end else begin
                                bit_idx_r <= bit_idx_r + 3'd1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CW'(1);
                        end
                    end
                    RX_STOP: begin
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_r  <= {CW{1'b0}};
                            rx_state_r <= RX_IDLE;
                            if (rxs_r) begin
                                byte_r     <= shift_r;
                                byte_vld_r <= 1'b1;
                            end else begin
                                frame_err_r <= 1'b1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CW'(1);
                        end
                    end
                    default: begin
                        rx_state_r <= RX_IDLE;
                        bit_cnt_r  <= {CW{1'b0}};
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Load sequencer
    // ------------------------------------------------------------------
    ld_state_t     ld_state_r;
    logic [8:0]    word_cnt_r;
    logic [8:0]    words_done_r;
    logic [1:0]    byte_idx_r;
    logic [23:0]   asm_r;
    logic [7:0]    next_addr_r;
    logic [TW-1:0] tmo_r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_r;
`endif

    // Load protocol: count byte, word assembly and write strobes, completion and abort handling.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state_r   <= L_IDLE;
            word_cnt_r   <= 9'd0;
            words_done_r <= 9'd0;
            byte_idx_r   <= 2'd0;
            asm_r        <= 24'd0;
            next_addr_r  <= 8'd0;
            tmo_r        <= {TW{1'b0}};
`ifdef LOADER_CHECKSUM_EN
            csum_r       <= 8'd0;
`endif
            core_hold    <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= 8'd0;
            imem_wdata   <= 32'd0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            if ((ld_state_r != L_IDLE) && !load_en) begin
                // Host disarmed the loader: silent abort.
                ld_state_r <= L_IDLE;
                core_hold  <= 1'b0;
            end else if ((ld_state_r != L_IDLE) && frame_err_r) begin
                ld_state_r <= L_IDLE;
                core_hold  <= 1'b0;
                load_err   <= 1'b1;
            end else begin
                case (ld_state_r)
                    L_IDLE: begin
                        if (byte_vld_r && load_en) begin
                            word_cnt_r   <= (byte_r == 8'd0) ? 9'd256 : {1'b0, byte_r};
                            words_done_r <= 9'd0;
                            byte_idx_r   <= 2'd0;
                            next_addr_r  <= 8'd0;
                            imem_addr    <= 8'd0;
                            tmo_r        <= {TW{1'b0}};
`ifdef LOADER_CHECKSUM_EN
                            csum_r       <= 8'd0;
`endif
                            core_hold    <= 1'b1;
                            ld_state_r   <= L_WORDS;
                        end
                    end
                    L_WORDS: begin
                        if (byte_vld_r) begin
                            // A byte arriving in the timeout cycle takes priority.
                            tmo_r <= {TW{1'b0}};
`ifdef LOADER_CHECKSUM_EN
                            csum_r <= csum_next(csum_r, byte_r);
`endif
                            if (byte_idx_r == 2'd3) begin
                                imem_we     <= 1'b1;
                                imem_addr   <= next_addr_r;
                                imem_wdata  <= {byte_r, asm_r};
                                next_addr_r <= next_addr_r + 8'd1;
                                byte_idx_r  <= 2'd0;
                                if (words_done_r == (word_cnt_r - 9'd1)) begin
`ifdef LOADER_CHECKSUM_EN
                                    ld_state_r <= L_CHECK;
`else
                                    ld_state_r <= L_FINISH;
`endif
                                end else begin
                                    words_done_r <= words_done_r + 9'd1;
                                end
                            end else begin
                                asm_r      <= {byte_r, asm_r[23:8]};
                                byte_idx_r <= byte_idx_r + 2'd1;
                            end
                        end else if (tmo_r == TMO_LAST) begin
                            ld_state_r <= L_IDLE;
                            core_hold  <= 1'b0;
                            load_err   <= 1'b1;
                        end else begin
                            tmo_r <= tmo_r + TW'(1);
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    L_CHECK: begin
                        if (byte_vld_r) begin
                            ld_state_r <= L_IDLE;
                            core_hold  <= 1'b0;
                            if (byte_r == csum_r) begin
                                load_done <= 1'b1;
                            end else begin
                                load_err <= 1'b1;
                            end
                        end else if (tmo_r == TMO_LAST) begin
                            ld_state_r <= L_IDLE;
                            core_hold  <= 1'b0;
                            load_err   <= 1'b1;
                        end else begin
                            tmo_r <= tmo_r + TW'(1);
                        end
                    end
`endif
                    L_FINISH: begin
                        load_done  <= 1'b1;
                        core_hold  <= 1'b0;
                        ld_state_r <= L_IDLE;
                    end
                    default: begin
                        ld_state_r <= L_IDLE;
                        core_hold  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Testbench for uart_imem_loader: drives UART frames, keeps a queue of
// expected memory writes and counts done/error pulses per scenario.
// Honors LOADER_CHECKSUM_EN the same way the design does.
`timescale 1ns/1ps
module tb_uart_imem_loader;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned TMO    = 500;
    localparam int          DIV    = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        load_en;
    logic        core_hold;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        load_done;
    logic        load_err;

    uart_imem_loader #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .load_en(load_en),
        .core_hold(core_hold),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .load_done(load_done),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   we_cnt = 0, done_cnt = 0, err_cnt = 0;
    int   base_we = 0, base_done = 0, base_err = 0;
    int   cyc = 0, err_cyc = 0;
    logic prev_hold = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        base_we   = we_cnt;
        base_done = done_cnt;
        base_err  = err_cnt;
    endtask

    task automatic expect_events(input string tag, input int dw, input int dd, input int de);
        check_val({tag, "_we"},   32'(we_cnt - base_we),     32'(dw));
        check_val({tag, "_done"}, 32'(done_cnt - base_done), 32'(dd));
        check_val({tag, "_err"},  32'(err_cnt - base_err),   32'(de));
    endtask

    // 8N1 frame, caller is at a falling clock edge; stop bit value selectable.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], 1'b1);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on each write and checks pulse rules.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (imem_we) begin
            we_cnt++;
            check_val("we_expected", 32'(exp_q.size() != 0), 32'd1);
            check_val("we_hold", 32'(core_hold), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("we_addr", 32'(imem_addr), 32'(e.addr));
                check_val("we_data", imem_wdata, e.data);
            end
        end
        if (load_done) begin
            done_cnt++;
            check_val("done_hold_fall", 32'(core_hold), 32'd0);
            check_val("done_hold_prev", 32'(prev_hold), 32'd1);
            check_val("done_err_excl", 32'(load_err), 32'd0);
        end
        if (load_err) begin
            err_cnt++;
            err_cyc = cyc;
            check_val("err_hold_fall", 32'(core_hold), 32'd0);
            check_val("err_hold_prev", 32'(prev_hold), 32'd1);
        end
        prev_hold = core_hold;
    end

    initial begin
        int t0;
        reset   = 1'b1;
        rx      = 1'b1;
        load_en = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check_val("rst_hold",  32'(core_hold),  32'd0);
        check_val("rst_we",    32'(imem_we),    32'd0);
        check_val("rst_addr",  32'(imem_addr),  32'd0);
        check_val("rst_wdata", imem_wdata,      32'd0);
        check_val("rst_done",  32'(load_done),  32'd0);
        check_val("rst_err",   32'(load_err),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        mark();
        repeat (30) @(negedge clk);
        #1;
        expect_events("idle", 0, 0, 0);
        check_val("idle_hold", 32'(core_hold), 32'd0);

        // Two-word program load.
        @(negedge clk);
        mark();
        exp_q.push_back('{8'h00, 32'h0000_0013});
        exp_q.push_back('{8'h01, 32'h0010_0073});
        send_byte(8'h02, 1'b1);
        #1;
        check_val("t2_hold_up", 32'(core_hold), 32'd1);
        @(negedge clk);
        send_word(32'h0000_0013);
        send_word(32'h0010_0073);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h70, 1'b1);
`endif
        repeat (20) @(negedge clk);
        #1;
        expect_events("t2", 2, 1, 0);
        check_val("t2_hold_down", 32'(core_hold), 32'd0);
        check_val("t2_addr_held", 32'(imem_addr), 32'd1);
        check_val("t2_data_held", imem_wdata, 32'h0010_0073);

        // Frame error inside a load.
        @(negedge clk);
        mark();
        send_byte(8'h01, 1'b1);
        send_byte(8'hA5, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        expect_events("t3", 0, 0, 1);
        check_val("t3_hold", 32'(core_hold), 32'd0);

        // Inter-byte timeout.
        @(negedge clk);
        mark();
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        t0 = cyc;
        repeat (600) @(negedge clk);
        #1;
        expect_events("t4", 0, 0, 1);
        check_val("t4_tmo_not_early", 32'((err_cyc - t0) >= 490), 32'd1);
        check_val("t4_tmo_not_late",  32'((err_cyc - t0) <= 505), 32'd1);
        check_val("t4_hold", 32'(core_hold), 32'd0);

        // Short low glitch while idle.
        @(negedge clk);
        mark();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        expect_events("t5g", 0, 0, 0);
        check_val("t5g_hold", 32'(core_hold), 32'd0);

        // load_en dropped mid-word, then a frame while disarmed.
        @(negedge clk);
        mark();
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        #1;
        check_val("t5e_hold_up", 32'(core_hold), 32'd1);
        @(negedge clk);
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("t5e_hold_drop", 32'(core_hold), 32'd0);
        @(negedge clk);
        send_byte(8'h01, 1'b1);
        repeat (10) @(negedge clk);
        #1;
        check_val("t5e_disarmed_hold", 32'(core_hold), 32'd0);
        @(negedge clk);
        load_en = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        expect_events("t5e", 0, 0, 0);

        // Single word; with checksum enabled, deliberately wrong checksum.
        @(negedge clk);
        mark();
        exp_q.push_back('{8'h00, 32'h4433_2211});
        send_byte(8'h01, 1'b1);
        send_word(32'h4433_2211);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        expect_events("t6", 1, 0, 1);
`else
        repeat (20) @(negedge clk);
        #1;
        expect_events("t6", 1, 1, 0);
`endif
        check_val("t6_hold", 32'(core_hold), 32'd0);

        // Reset asserted mid-load.
        @(negedge clk);
        mark();
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_val("t7_hold",  32'(core_hold), 32'd0);
        check_val("t7_addr",  32'(imem_addr), 32'd0);
        check_val("t7_wdata", imem_wdata,     32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        expect_events("t7", 0, 0, 0);

        // Fresh load after reset.
        @(negedge clk);
        mark();
        exp_q.push_back('{8'h00, 32'hDEAD_BEEF});
        send_byte(8'h01, 1'b1);
        send_word(32'hDEAD_BEEF);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h22, 1'b1);
`endif
        repeat (20) @(negedge clk);
        #1;
        expect_events("t8", 1, 1, 0);
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
